touch_adc_reader: RTL and testbench

Drives the resistive touch-panel controller (ADS7846-class, SPI-style serial ADC) and produces the `tor_x`/`tor_y` coordinate pair that the touch-region detectors consume. On a pen-down interrupt it runs a Y conversion, then an X conversion, and scales both to screen coordinates. If the pen is still down, it publishes them with a one-cycle `tor_valid` strobe and repeats at a fixed rate while the touch is held. It sits between the panel controller pins and all touch-zone logic.

---
 rtl/touch_pkg.sv | 32 +++
 rtl/touch_dclk_gen.sv | 61 ++++++
 rtl/touch_adc_reader.sv | 219 +++++++++++++++++++++
 tb/tb_touch_adc_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// -----------------------------------------------------------------------------
// touch_pkg
// Shared definitions for the resistive touch-panel reader:
//   - controller command bytes for the Y and X conversions
//   - default screen clamp limits
//   - frame geometry (dclk periods per conversion / per frame)
//   - the reader FSM state enumeration
// -----------------------------------------------------------------------------
package touch_pkg;

  // Start bit, channel select, 12-bit mode, differential, power-down between
  // conversions. Y is measured first, then X.
  localparam logic [7:0] CMD_Y = 8'h90;
  localparam logic [7:0] CMD_X = 8'hD0;

  localparam int DEF_X_MAX = 639;
  localparam int DEF_Y_MAX = 479;

  // One conversion is 24 dclk periods: 8 command bits, 1 busy bit,
  // 12 data bits, 3 trailing zeros. A frame is Y then X back to back.
  localparam int CONV_BITS  = 24;
  localparam int FRAME_BITS = 2 * CONV_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_CHECK,
    ST_PUBLISH,
    ST_WAIT_GAP
  } state_e;

endpackage : touch_pkg

// File: rtl/touch_dclk_gen.sv
// -----------------------------------------------------------------------------
// touch_dclk_gen
// Serial clock and bit sequencer for one 48-period conversion frame.
// While en_i is high it runs dclk with a 2*CLK_DIV clk period (low half
// first) and counts bit periods 0..47. While en_i is low everything is held
// at zero so each frame starts cleanly at bit 0, low half.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   en_i         high for the whole frame
//   dclk_o       serial clock to the controller
//   low_start_o  first clk of a period's low half
//   high_end_o   last clk of a period's high half (last cycle of the period)
//   bit_idx_o    current period index within the frame, 0..47
// -----------------------------------------------------------------------------
module touch_dclk_gen
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  output logic       dclk_o,
  output logic       low_start_o,
  output logic       high_end_o,
  output logic [5:0] bit_idx_o
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] PHASE_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] PHASE_HIGH = DW'(CLK_DIV);
  localparam logic [5:0]    BIT_LAST   = 6'(FRAME_BITS - 1);

  logic [DW-1:0] phase_q;
  logic [5:0]    bit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      bit_q   <= '0;
    end else if (!en_i) begin
      phase_q <= '0;
      bit_q   <= '0;
    end else if (phase_q == PHASE_LAST) begin
      phase_q <= '0;
      bit_q   <= (bit_q == BIT_LAST) ? '0 : bit_q + 6'd1;
    end else begin
      phase_q <= phase_q + DW'(1);
    end
  end

  // Decoded from registers and the enable, so dclk drops to idle-low in the
  // same cycle the frame is abandoned.
  assign dclk_o      = en_i && (phase_q >= PHASE_HIGH);
  assign low_start_o = en_i && (phase_q == '0);
  assign high_end_o  = en_i && (phase_q == PHASE_LAST);
  assign bit_idx_o   = bit_q;

endmodule : touch_dclk_gen

// File: rtl/touch_adc_reader.sv
// -----------------------------------------------------------------------------
// touch_adc_reader
// Reads an ADS7846-class touch controller: on pen-down it runs a Y then an X
// conversion in one chip-select frame, scales the raw 12-bit results to
// screen coordinates, and publishes them if the pen is still down. While the
// pen is held, frames repeat after SAMPLE_GAP idle cycles.
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   penirq_n      pen interrupt from the controller (async, active-low)
//   dout          serial data from the controller (async)
//   cs_n          controller chip select, low for the whole frame
//   dclk          serial clock
//   din           serial command to the controller
//   tor_x         screen x, 0..X_MAX, held between publishes
//   tor_y         screen y, 0..Y_MAX, held between publishes
//   tor_valid     one-cycle strobe on publish
//   touch_active  high from first publish until the pen is seen released
// -----------------------------------------------------------------------------
module touch_adc_reader
  import touch_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_GAP = 100,
  parameter int X_MAX      = DEF_X_MAX,
  parameter int Y_MAX      = DEF_Y_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       penirq_n,
  input  logic       dout,
  output logic       cs_n,
  output logic       dclk,
  output logic       din,
  output logic [9:0] tor_x,
  output logic [8:0] tor_y,
  output logic       tor_valid,
  output logic       touch_active
);

  localparam int GW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(SAMPLE_GAP - 1);
  localparam logic [9:0]    X_LIM    = 10'(X_MAX);
  localparam logic [8:0]    Y_LIM    = 9'(Y_MAX);

  state_e        state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]    pen_sync_q;
  logic [1:0]    dout_sync_q;
  logic [11:0]   raw_sr_q;
  logic [11:0]   raw_y_q;
  logic [9:0]    tor_x_q;
  logic [8:0]    tor_y_q;
  logic          active_q;

  logic          pen_n;
  logic          frame_en;
  logic          low_start;
  logic          high_end;
  logic [5:0]    bit_idx;
  logic [5:0]    conv_k;
  logic [7:0]    cmd;
  logic          frame_done;
  logic          load_pub;
  logic          clear_active;
  logic [9:0]    x_full, x_scaled;
  logic [8:0]    y_full, y_scaled;

  // ---------------------------------------------------------------------------
  // Input synchronizers. The pen synchronizer resets to "released" so a reset
  // never looks like a pen-down edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pen_sync_q  <= 2'b11;
      dout_sync_q <= 2'b00;
    end else begin
      // NOTE: flops always take non-blocking assignments so every register in
      // the chain samples the pre-edge value; blocking here would collapse
      // the two stages into one.
      pen_sync_q  <= {pen_sync_q[0], penirq_n};
      dout_sync_q <= {dout_sync_q[0], dout};
    end
  end

  assign pen_n = pen_sync_q[1];

  // ---------------------------------------------------------------------------
  // Serial sequencer
  // ---------------------------------------------------------------------------
  assign frame_en = (state_q == ST_FRAME);

  touch_dclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_dclk_gen (
    .clk         (clk),
    .reset       (reset),
    .en_i        (frame_en),
    .dclk_o      (dclk),
    .low_start_o (low_start),
    .high_end_o  (high_end),
    .bit_idx_o   (bit_idx)
  );

  // Bit position within the current conversion, 0..23.
  assign conv_k     = (bit_idx >= 6'(CONV_BITS)) ? bit_idx - 6'(CONV_BITS) : bit_idx;
  assign cmd        = (bit_idx < 6'(CONV_BITS)) ? CMD_Y : CMD_X;
  assign frame_done = high_end && (bit_idx == 6'(FRAME_BITS - 1));

  // The bit index advances on the first clk of a low half, so din changes
  // there and is stable across the rising dclk edge. ~k == 7-k for 3 bits.
  assign din  = frame_en && (conv_k < 6'd8) && cmd[~conv_k[2:0]];
  assign cs_n = !frame_en;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    load_pub     = 1'b0;
    clear_active = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!pen_n) state_d = ST_FRAME;
      end
      ST_FRAME: begin
        // The controller toggles penirq_n while converting; ignore it here.
        if (frame_done) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!pen_n) begin
          state_d  = ST_PUBLISH;
          load_pub = 1'b1;
        end else begin
          state_d      = ST_IDLE;
          clear_active = 1'b1;
        end
      end
      ST_PUBLISH: begin
        state_d   = ST_WAIT_GAP;
        gap_cnt_d = '0;
      end
      ST_WAIT_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!pen_n) begin
            state_d = ST_FRAME;
          end else begin
            state_d      = ST_IDLE;
            clear_active = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture and scaling
  // ---------------------------------------------------------------------------
  // Data bits sit at conversion periods 9..20, MSB first. Shifting at the end
  // of the high half gives the synchronizer the whole high half to settle.
  // At the end of the frame raw_sr_q holds the X result; Y is parked in
  // raw_y_q at the end of the Y conversion.
  assign x_full   = 10'(raw_sr_q >> 2);
  assign y_full   = 9'(raw_y_q >> 3);
  assign x_scaled = (x_full > X_LIM) ? X_LIM : x_full;
  assign y_scaled = (y_full > Y_LIM) ? Y_LIM : y_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the raw capture registers are fully rewritten every frame and
      // need no reset for correctness; they are reset anyway so nothing
      // unknown can reach the coordinate outputs.
      raw_sr_q <= '0;
      raw_y_q  <= '0;
      tor_x_q  <= '0;
      tor_y_q  <= '0;
      active_q <= 1'b0;
    end else begin
      if (low_start && (conv_k == 6'd0)) begin
        raw_sr_q <= '0;
      end else if (high_end && (conv_k >= 6'd9) && (conv_k <= 6'd20)) begin
        raw_sr_q <= {raw_sr_q[10:0], dout_sync_q[1]};
      end

      if (high_end && (bit_idx == 6'(CONV_BITS - 1))) raw_y_q <= raw_sr_q;

      if (load_pub) begin
        tor_x_q <= x_scaled;
        tor_y_q <= y_scaled;
      end

      if (load_pub)          active_q <= 1'b1;
      else if (clear_active) active_q <= 1'b0;
    end
  end

  assign tor_x        = tor_x_q;
  assign tor_y        = tor_y_q;
  assign tor_valid    = (state_q == ST_PUBLISH);
  assign touch_active = active_q;

endmodule : touch_adc_reader

// File: tb/tb_touch_adc_reader.sv
// -----------------------------------------------------------------------------
// tb_touch_adc_reader
// Bench for touch_adc_reader with default parameters (CLK_DIV=4,
// SAMPLE_GAP=100). A controller model answers the serial frame with preset
// raw values and records the command bytes; expected coordinates are queued
// as each touch is issued and a monitor pops them on every tor_valid.
// -----------------------------------------------------------------------------
module tb_touch_adc_reader;

  localparam int CLK_DIV    = 4;
  localparam int SAMPLE_GAP = 100;
  localparam int LATENCY    = 96 * CLK_DIV + 1;
  localparam int INTERVAL   = 96 * CLK_DIV + SAMPLE_GAP + 2;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       penirq_n = 1'b1;
  logic       dout = 1'b0;
  logic       cs_n, dclk, din, tor_valid, touch_active;
  logic [9:0] tor_x;
  logic [8:0] tor_y;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t exp_q[$];
  int   n_strobes       = 0;
  int   last_strobe_cyc = 0;
  int   fall_cyc        = 0;
  logic expect_interval = 1'b0;

  logic [11:0] raw_y_m = '0;
  logic [11:0] raw_x_m = '0;
  int          bitcnt  = 0;

  touch_adc_reader #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_GAP (SAMPLE_GAP),
    .X_MAX      (639),
    .Y_MAX      (479)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .penirq_n     (penirq_n),
    .dout         (dout),
    .cs_n         (cs_n),
    .dclk         (dclk),
    .din          (din),
    .tor_x        (tor_x),
    .tor_y        (tor_y),
    .tor_valid    (tor_valid),
    .touch_active (touch_active)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Controller model: shifts in the command on rising dclk and presents the
  // raw result bits from the rising edge of periods 9..20 of each conversion.
  initial begin
    logic       prev_dclk;
    logic [7:0] cap_y, cap_x;
    int         k;
    prev_dclk = 1'b0;
    cap_y     = '0;
    cap_x     = '0;
    forever begin
      @(negedge clk);
      if (cs_n) begin
        if (bitcnt == 48) begin
          check("cmd_y", cap_y, 8'h90);
          check("cmd_x", cap_x, 8'hD0);
        end
        bitcnt = 0;
        dout   = 1'b0;
      end else if (dclk && !prev_dclk) begin
        k = bitcnt % 24;
        if (k < 8) begin
          if (bitcnt < 24) cap_y = {cap_y[6:0], din};
          else             cap_x = {cap_x[6:0], din};
        end
        if (k >= 9 && k <= 20) dout = (bitcnt < 24) ? raw_y_m[20-k] : raw_x_m[20-k];
        else                   dout = 1'b0;
        bitcnt++;
      end
      prev_dclk = dclk;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_cs;
    logic chk_low;
    exp_t e;
    prev_cs = 1'b1;
    chk_low = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_cs && !cs_n) fall_cyc = cyc;
      prev_cs = cs_n;
      if (chk_low) begin
        check("valid_one_cycle", tor_valid, 1'b0);
        chk_low = 1'b0;
      end
      if (tor_valid) begin
        n_strobes++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", tor_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_x", tor_x, e.x);
          check("strobe_y", tor_y, e.y);
          check("strobe_active", touch_active, 1'b1);
          check("strobe_latency", cyc - fall_cyc, LATENCY);
          if (expect_interval) check("strobe_interval", cyc - last_strobe_cyc, INTERVAL);
        end
        last_strobe_cyc = cyc;
        chk_low = 1'b1;
      end
    end
  end

  task automatic wait_strobes(input int target, input int budget, input string name);
    int n = 0;
    while (n_strobes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n_strobes, target);
  endtask

  task automatic wait_inactive(input int budget, input string name);
    int n = 0;
    while (touch_active && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, touch_active, 1'b0);
  endtask

  task automatic press_and_time_cs(input string name);
    int t0, n;
    @(negedge clk);
    t0 = cyc;
    penirq_n = 1'b0;
    n = 0;
    while (cs_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, cyc - t0, 3);
  endtask

  initial begin
    int cs_low, inact, n, s0, t0;

    // Reset values and idle behaviour.
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_dclk", dclk, 1'b0);
    check("rst_din", din, 1'b0);
    check("rst_tor_x", tor_x, 10'd0);
    check("rst_tor_y", tor_y, 9'd0);
    check("rst_tor_valid", tor_valid, 1'b0);
    check("rst_touch_active", touch_active, 1'b0);
    reset = 1'b0;
    cs_low = 0;
    repeat (60) begin
      @(negedge clk);
      if (!cs_n) cs_low++;
    end
    check("idle_cs_low_cycles", cs_low, 0);

    // Basic touch: Y 0x800 -> 256, X 0x400 -> 256.
    raw_y_m = 12'h800;
    raw_x_m = 12'h400;
    exp_q.push_back('{x: 10'd256, y: 9'd256});
    press_and_time_cs("basic_pen_to_cs");
    wait_strobes(1, 500, "basic_strobe_count");
    penirq_n = 1'b1;
    wait_inactive(200, "basic_release_inactive");

    // Clamp: full-scale raw values.
    raw_y_m = 12'hFFF;
    raw_x_m = 12'hFFF;
    exp_q.push_back('{x: 10'd639, y: 9'd479});
    press_and_time_cs("clamp_pen_to_cs");
    wait_strobes(2, 500, "clamp_strobe_count");
    penirq_n = 1'b1;
    wait_inactive(200, "clamp_release_inactive");
    check("clamp_hold_x", tor_x, 10'd639);
    check("clamp_hold_y", tor_y, 9'd479);

    // Release during the X conversion: the frame is discarded.
    raw_y_m = 12'h123;
    raw_x_m = 12'h456;
    press_and_time_cs("discard_pen_to_cs");
    n = 0;
    while (bitcnt < 30 && n < 400) begin
      @(negedge clk);
      n++;
    end
    penirq_n = 1'b1;
    s0 = n_strobes;
    repeat (450) @(negedge clk);
    check("discard_no_strobe", n_strobes, s0);
    check("discard_inactive", touch_active, 1'b0);
    check("discard_hold_x", tor_x, 10'd639);
    check("discard_hold_y", tor_y, 9'd479);
    check("discard_cs_idle", cs_n, 1'b1);

    // Held touch: two frames, raw values changed in between.
    raw_y_m = 12'h600;
    raw_x_m = 12'h900;
    exp_q.push_back('{x: 10'd576, y: 9'd192});
    press_and_time_cs("held_pen_to_cs");
    wait_strobes(3, 500, "held_first_strobe");
    raw_y_m = 12'h2A8;
    raw_x_m = 12'h7FC;
    exp_q.push_back('{x: 10'd511, y: 9'd85});
    expect_interval = 1'b1;
    inact = 0;
    n = 0;
    while (n_strobes < 4 && n < 700) begin
      @(negedge clk);
      if (!touch_active) inact++;
      n++;
    end
    check("held_second_strobe", n_strobes, 4);
    check("held_active_between", inact, 0);
    penirq_n = 1'b1;
    expect_interval = 1'b0;
    n = 0;
    while (touch_active && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_release_at_gap_end", cyc - last_strobe_cyc, SAMPLE_GAP + 1);

    // Reset in the high half of bit 20, then a full new frame.
    raw_y_m = 12'h0F8;
    raw_x_m = 12'h03C;
    press_and_time_cs("rstmid_pen_to_cs");
    n = 0;
    while (bitcnt < 21 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_dclk_high_before", dclk, 1'b1);
    s0 = n_strobes;
    reset = 1'b1;
    #1;
    check("rstmid_cs_n", cs_n, 1'b1);
    check("rstmid_dclk", dclk, 1'b0);
    check("rstmid_tor_valid", tor_valid, 1'b0);
    exp_q.push_back('{x: 10'd15, y: 9'd31});
    repeat (2) @(negedge clk);
    t0 = cyc;
    reset = 1'b0;
    n = 0;
    while (cs_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_restart_delay", cyc - t0, 3);
    check("rstmid_no_strobe", n_strobes, s0);
    wait_strobes(s0 + 1, 500, "rstmid_new_frame_strobe");
    penirq_n = 1'b1;
    wait_inactive(200, "rstmid_release_inactive");

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_touch_adc_reader
